// File: rtl/calculator_pkg.sv
// ============================================================================
// calculator_pkg
// Shared widths and the writeback FSM state type for the calculator datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL_LO = 3'd1,
        FILL_HI = 3'd2,
        CAPTURE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/result_writeback.sv
// ============================================================================
// result_writeback
// Collects two 32-bit ALU results per 64-bit word and writes NUM_WORDS words
// to memory from BASE_ADDR. Optional RESULT_WB_FLUSH_EN adds flush_i.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_writeback
    import calculator_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
`ifdef RESULT_WB_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    output logic                     loc_sel_o,
    input  logic [MEM_WORD_SIZE-1:0] buffer_i,
    output logic                     mem_wr_en_o,
    output logic [ADDR_W-1:0]        mem_wr_addr_o,
    output logic [MEM_WORD_SIZE-1:0] mem_wr_data_o,
    input  logic                     mem_wr_ready_i,
    output logic                     done_o
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);

    wb_state_t                state_q;
    logic [ADDR_W-1:0]        count_q;
    logic [MEM_WORD_SIZE-1:0] data_q;
    logic [MEM_WORD_SIZE-1:0] data_d;

`ifdef RESULT_WB_FLUSH_EN
    logic flushed_q;

    // A flushed word carries only the lower result; the upper half is stale.
    assign data_d = flushed_q ? {{DATA_W{1'b0}}, buffer_i[DATA_W-1:0]} : buffer_i;
`else
    assign data_d = buffer_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            data_q    <= '0;
`ifdef RESULT_WB_FLUSH_EN
            flushed_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= FILL_LO;
                        count_q <= '0;
                    end
                end
                FILL_LO: begin
                    if (res_valid_i) state_q <= FILL_HI;
                end
                FILL_HI: begin
                    if (res_valid_i) begin
                        state_q   <= CAPTURE;
`ifdef RESULT_WB_FLUSH_EN
                        flushed_q <= 1'b0;
                    end else if (flush_i) begin
                        state_q   <= CAPTURE;
                        flushed_q <= 1'b1;
`endif
                    end
                end
                CAPTURE: begin
                    data_q  <= data_d;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (mem_wr_ready_i) begin
                        if (count_q == c_last) begin
                            state_q <= DONE;
                        end else begin
                            count_q <= count_q + 1'b1;
                            state_q <= FILL_LO;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pure decodes of registered state so reset removes them without a clock.
    assign res_ready_o   = (state_q == FILL_LO) || (state_q == FILL_HI);
    assign loc_sel_o     = (state_q == FILL_HI);
    assign mem_wr_en_o   = (state_q == WRITE);
    assign done_o        = (state_q == DONE);
    assign mem_wr_addr_o = c_base + count_q;
    assign mem_wr_data_o = data_q;

endmodule

`default_nettype wire

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 4, meaning the number of 64-bit words written per job (legal range 1..2**ADDR_W).
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the memory address of the first word written in a job.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. Ports: clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-004 SHALL have port start_i  in  1  begin job (pulse).
REQ-005 SHALL have ports res_valid_i  in  1  ALU result valid; res_ready_o  out  1  result accepted this cycle when both are high.
REQ-006 SHALL have port loc_sel_o  out  1  buffer half select to the result buffer (0 = bits [31:0], 1 = bits [63:32]).
REQ-007 SHALL have port buffer_i  in  MEM_WORD_SIZE  result buffer contents.
REQ-008 SHALL have ports mem_wr_en_o  out  1; mem_wr_addr_o  out  ADDR_W; mem_wr_data_o  out  MEM_WORD_SIZE; mem_wr_ready_i  in  1 (write completes on a cycle with en and ready both high).
REQ-009 SHALL have port done_o  out  1  job complete.

Function
REQ-010 SHALL implement the FSM states IDLE, FILL_LO, FILL_HI, CAPTURE, WRITE and DONE.
REQ-011 IDLE: start_i -> FILL_LO, word count cleared; otherwise hold.
REQ-012 FILL_LO: res_ready_o=1, loc_sel_o=0; on accept -> FILL_HI.
REQ-013 FILL_HI: res_ready_o=1, loc_sel_o=1; on accept -> CAPTURE.
REQ-014 CAPTURE: one cycle; res_ready_o=0, loc_sel_o=0; latches buffer_i into the write data register at the cycle end -> WRITE.
REQ-015 WRITE: mem_wr_en_o=1, data = latched register, addr = BASE_ADDR + word count (truncated to ADDR_W, wrap permitted).
REQ-016 WRITE: mem_wr_en_o, address and data SHALL hold stable until mem_wr_ready_i is high.
REQ-017 On a completed write, if count == NUM_WORDS-1 -> DONE, else count+1 -> FILL_LO.
REQ-018 DONE: done_o=1; start_i -> FILL_LO with count cleared.
REQ-019 Latency: mem_wr_en_o SHALL first assert two cycles after the cycle in which the upper-half result is accepted.
REQ-020 res_valid_i while res_ready_o=0 SHALL be ignored and SHALL NOT be counted.
REQ-021 start_i outside IDLE/DONE SHALL be ignored.
REQ-022 NUM_WORDS=1: the first completed write SHALL go directly to DONE.
REQ-023 res_ready_o, mem_wr_en_o and done_o SHALL be registered-state decodes only, with no combinational path from any input.

Reset
REQ-024 rst_i SHALL asynchronously force: state=IDLE, count=0, data register=0, res_ready_o=0, loc_sel_o=0, mem_wr_en_o=0, mem_wr_addr_o=BASE_ADDR, mem_wr_data_o=0, done_o=0.
REQ-025 Reset mid-WRITE SHALL drop mem_wr_en_o immediately (no clock required); the aborted word SHALL NOT be retried after reset.

Configuration
REQ-026 Macro RESULT_WB_FLUSH_EN, when defined, SHALL add port flush_i  in  1.
REQ-027 With the macro: in FILL_HI, flush_i=1 with no accept -> CAPTURE, and the latched upper 32 bits are forced to 0; then normal WRITE/count.
REQ-028 With the macro: flush_i in any other state SHALL be ignored; if valid and flush coincide in FILL_HI, the accept wins (normal path).
REQ-029 Without the macro: no flush_i port; FILL_HI exits only on accept.

Structure
REQ-030 DATA_W (32), MEM_WORD_SIZE (64), ADDR_W and the state enum type wb_state_t SHALL live in calculator_pkg.
REQ-031 The block SHALL contain no sub-module; the FSM, counter and data register are in one module.

Verification
REQ-032 Bench: NUM_WORDS=2, BASE_ADDR=8, start then results 1,2,3,4 back-to-back -> writes addr 8 data 0x00000002_00000001, addr 9 data 0x00000004_00000003, then done_o=1.
REQ-033 Bench: hold mem_wr_ready_i=0 for 5 cycles in WRITE -> en/addr/data stable for 6 cycles, res_ready_o=0 throughout, a single write occurs.
REQ-034 Bench: res_valid_i pulsed during CAPTURE/WRITE -> ignored; word count and data unchanged.
REQ-035 Bench: rst_i asserted mid-WRITE between clock edges -> mem_wr_en_o low before the next edge; state IDLE; start_i restarts at BASE_ADDR.
REQ-036 Bench (RESULT_WB_FLUSH_EN): lower result 0xDEADBEEF, then flush_i -> write data 0x00000000_DEADBEEF.
REQ-037 Bench: NUM_WORDS=1, start_i asserted in DONE -> new job at BASE_ADDR; start_i in FILL_HI -> ignored.
